// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath: decodes the opcode and
// sequences fetch/decode/execute/memory/writeback, driving datapath selects.
module mips_mc_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:  cur <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYP:      cur <= EXECUTE;
                        OP_BEQ:       cur <= BRANCH;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                // Anything that is not lw here is treated as sw.
                MEMADR:  cur <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   cur <= MEMWB;
                EXECUTE: cur <= ALUWB;
                ADDIEX:  cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    // Moore decode; write enables are additionally held off while in reset so
    // nothing is written before the first real fetch cycle.
    always_comb begin
        iord     = 1'b0;
        alusrca  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB:  regwrite = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (!reset_n) begin
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = cur;

endmodule
